// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: register offsets, FSM
// state encoding, default window base and the address-decode helper.
package mmio_port_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  localparam logic [1:0] OFS_PORT_OUT = 2'd0;
  localparam logic [1:0] OFS_PORT_IN  = 2'd1;
  localparam logic [1:0] OFS_STATUS   = 2'd2;
  localparam logic [1:0] OFS_CYCLES   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mmioState;

  // Word-aligned access inside the 16-byte window; address bits [3:2] select the register.
  function automatic logic addrHit(input logic [27:0] addrHi, input logic [1:0] addrLo,
                                   input logic [27:0] baseHi);
    return (addrHi == baseHi) && (addrLo == 2'b00);
  endfunction

endpackage

// File: rtl/mmio_port_responder_input_synchronizer.sv
// Multi-flop synchronizer for an asynchronous bus, with a one-cycle pulse
// whenever the value about to enter the last stage differs from the last stage.
module input_synchronizer #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncData,
  output logic             changePulse
);

  logic [STAGES-1:0][WIDTH-1:0] stageReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stageReg <= '0;
    end else begin
      stageReg <= {stageReg[STAGES-2:0], asyncIn};
    end
  end

  assign syncData    = stageReg[STAGES-1];
  assign changePulse = (stageReg[STAGES-1] != stageReg[STAGES-2]);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder for the MIPS core: PortOut/PortIn registers, sticky input-change
// flag and a writable cycle counter behind a req/rsp handshake with wait states.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic [7:0]  port_in,
  output logic [31:0] port_out,
  output logic        in_change_irq
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mmioState    stateReg, stateNext;
  logic [3:0]  waitCntReg, waitCntNext;
  logic        accept, enterResp;

  logic        capWriteReg, capHitReg;
  logic [1:0]  capOfsReg;
  logic [31:0] portOutReg, cyclesReg, rspRdataReg;
  logic        changedReg, rspErrorReg;

  logic [7:0]  syncData;
  logic        syncChange;
  logic        reqHit, wrCommit;
  logic [1:0]  reqOfs;
  logic        respWrite, respHit;
  logic [1:0]  respOfs;
  logic [31:0] readData;

  input_synchronizer #(
    .WIDTH (8),
    .STAGES(SYNC_STAGES)
  ) portInSync (
    .clk        (clk),
    .reset      (reset),
    .asyncIn    (port_in),
    .syncData   (syncData),
    .changePulse(syncChange)
  );

  assign reqHit   = addrHit(req_addr[31:4], req_addr[1:0], BASE_ADDR[31:4]);
  assign reqOfs   = req_addr[3:2];
  assign wrCommit = accept && req_write && reqHit;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= ST_IDLE;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    accept      = 1'b0;
    enterResp   = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            stateNext = ST_RESP;
            enterResp = 1'b1;
          end else begin
            stateNext   = ST_WAIT;
            waitCntNext = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (waitCntReg == 4'd0) begin
          stateNext = ST_RESP;
          enterResp = 1'b1;
        end else begin
          waitCntNext = waitCntReg - 4'd1;
        end
      end
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    // With no wait states the response is built on the accept edge, straight from the bus.
    if (stateReg == ST_IDLE) begin
      respWrite = req_write;
      respHit   = reqHit;
      respOfs   = reqOfs;
    end else begin
      respWrite = capWriteReg;
      respHit   = capHitReg;
      respOfs   = capOfsReg;
    end
    case (respOfs)
      OFS_PORT_OUT: readData = portOutReg;
      OFS_PORT_IN:  readData = {24'd0, syncData};
      OFS_STATUS:   readData = {31'd0, changedReg};
      default:      readData = cyclesReg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      capWriteReg <= 1'b0;
      capHitReg   <= 1'b0;
      capOfsReg   <= '0;
      portOutReg  <= '0;
      cyclesReg   <= '0;
      changedReg  <= 1'b0;
      rspRdataReg <= '0;
      rspErrorReg <= 1'b0;
    end else begin
      if (accept) begin
        capWriteReg <= req_write;
        capHitReg   <= reqHit;
        capOfsReg   <= reqOfs;
      end
      if (wrCommit && reqOfs == OFS_PORT_OUT) begin
        portOutReg <= req_wdata;
      end
      if (wrCommit && reqOfs == OFS_CYCLES) begin
        cyclesReg <= req_wdata;
      end else begin
        cyclesReg <= cyclesReg + 32'd1;
      end
      // A new input change beats a simultaneous write-1-to-clear.
      if (syncChange) begin
        changedReg <= 1'b1;
      end else if (wrCommit && reqOfs == OFS_STATUS && req_wdata[0]) begin
        changedReg <= 1'b0;
      end
      if (enterResp) begin
        rspErrorReg <= !respHit;
        rspRdataReg <= (respWrite || !respHit) ? 32'd0 : readData;
      end else begin
        rspErrorReg <= 1'b0;
        rspRdataReg <= '0;
      end
    end
  end

  assign req_ready     = (stateReg == ST_IDLE);
  assign rsp_valid     = (stateReg == ST_RESP);
  assign rsp_rdata     = rspRdataReg;
  assign rsp_error     = rspErrorReg;
  assign port_out      = portOutReg;
  assign in_change_irq = changedReg;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed scenarios plus random traffic on a
// one-wait-state and a zero-wait-state instance, checked against an edge-level model.
module tb_mmio_port_responder;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  portIn;
  logic        aValid, aWrite, bValid, bWrite;
  logic [31:0] aAddr, aWdata, bAddr, bWdata;
  logic        aReady, aRspValid, aErr, aIrq, bReady, bRspValid, bErr, bIrq;
  logic [31:0] aRdata, aPortOut, bRdata, bPortOut;

  mmio_port_responder #(.BASE_ADDR(32'hFFFF_0000), .WAIT_STATES(1), .SYNC_STAGES(SYNC)) dutA (
    .clk(clk), .reset(reset), .req_valid(aValid), .req_write(aWrite), .req_addr(aAddr),
    .req_wdata(aWdata), .req_ready(aReady), .rsp_valid(aRspValid), .rsp_rdata(aRdata),
    .rsp_error(aErr), .port_in(portIn), .port_out(aPortOut), .in_change_irq(aIrq));

  mmio_port_responder #(.BASE_ADDR(32'hFFFF_0000), .WAIT_STATES(0), .SYNC_STAGES(SYNC)) dutB (
    .clk(clk), .reset(reset), .req_valid(bValid), .req_write(bWrite), .req_addr(bAddr),
    .req_wdata(bWdata), .req_ready(bReady), .rsp_valid(bRspValid), .rsp_rdata(bRdata),
    .rsp_error(bErr), .port_in(portIn), .port_out(bPortOut), .in_change_irq(bIrq));

  // sel=0 exercises dutA (one wait state), sel=1 exercises dutB (no wait states)
  logic        sel;
  logic        obsReady, obsRspValid, obsErr, obsIrq;
  logic [31:0] obsRdata, obsPortOut;
  assign obsReady    = sel ? bReady    : aReady;
  assign obsRspValid = sel ? bRspValid : aRspValid;
  assign obsErr      = sel ? bErr      : aErr;
  assign obsIrq      = sel ? bIrq      : aIrq;
  assign obsRdata    = sel ? bRdata    : aRdata;
  assign obsPortOut  = sel ? bPortOut  : aPortOut;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          ws;
  int          edgeNo;
  int          accEdge, respEdge;
  logic [31:0] mPortOut, mCycles, expRdata;
  logic        mFlag, expErr, mW, mHit;
  logic [1:0]  mOfs;
  logic [7:0]  samp[$];
  logic [31:0] lastRdata;
  logic        lastErr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d: observed %h expected %h", tag, edgeNo, obs, exp);
    end
  endtask

  function automatic bit modelReady();
    return !(edgeNo >= accEdge && edgeNo <= accEdge + ws);
  endfunction

  task automatic modelReset();
    mPortOut = 0; mCycles = 0; mFlag = 0;
    accEdge = -100; respEdge = -100;
    samp.delete();
    for (int i = 0; i < 6; i++) samp.push_back(8'd0);
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bValid = v; bWrite = w; bAddr = a; bWdata = d; aValid = 1'b0;
    end else begin
      aValid = v; aWrite = w; aAddr = a; aWdata = d; bValid = 1'b0;
    end
  endtask

  // One clock: advance the model across the edge, then compare at the falling edge.
  task automatic cycle();
    logic        vld, wr, hit, acc, isWr;
    logic [31:0] addr, wd;
    logic [1:0]  ofs;
    logic        setF, clrF;
    vld  = sel ? bValid : aValid;
    wr   = sel ? bWrite : aWrite;
    addr = sel ? bAddr  : aAddr;
    wd   = sel ? bWdata : aWdata;
    acc  = vld && modelReady() && !reset;
    @(posedge clk);
    edgeNo++;
    if (reset) begin
      modelReset();
    end else begin
      samp.push_front(portIn);
      void'(samp.pop_back());
      hit  = ((addr & 32'hFFFF_FFF0) == 32'hFFFF_0000) && (addr % 4 == 0);
      ofs  = 2'((addr % 16) / 4);
      isWr = acc && wr && hit;
      if (acc) begin
        accEdge = edgeNo; respEdge = edgeNo + ws;
        mW = wr; mHit = hit; mOfs = ofs;
      end
      if (respEdge == edgeNo) begin
        expErr = !mHit;
        if (mW || !mHit)        expRdata = 0;
        else if (mOfs == 2'd0)  expRdata = mPortOut;
        else if (mOfs == 2'd1)  expRdata = {24'd0, samp[SYNC]};
        else if (mOfs == 2'd2)  expRdata = {31'd0, mFlag};
        else                    expRdata = mCycles;
      end
      setF = (samp[SYNC-1] != samp[SYNC]);
      clrF = isWr && ofs == 2'd2 && wd[0];
      mCycles = (isWr && ofs == 2'd3) ? wd : mCycles + 1;
      if (isWr && ofs == 2'd0) mPortOut = wd;
      mFlag = setF || (mFlag && !clrF);
    end
    @(negedge clk);
    check("req_ready", {31'd0, obsReady}, {31'd0, modelReady()});
    check("rsp_valid", {31'd0, obsRspValid}, {31'd0, edgeNo == respEdge});
    if (edgeNo == respEdge) begin
      check("rsp_rdata", obsRdata, expRdata);
      check("rsp_error", {31'd0, obsErr}, {31'd0, expErr});
    end
    check("port_out", obsPortOut, mPortOut);
    check("in_change_irq", {31'd0, obsIrq}, {31'd0, mFlag});
  endtask

  task automatic doReq(input logic w, input logic [31:0] addr, input logic [31:0] d);
    for (int g = 0; g < 40 && !modelReady(); g++) cycle();
    drive(1'b1, w, addr, d);
    cycle();
    drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int g = 0; g < 40 && edgeNo < respEdge; g++) cycle();
    lastRdata = obsRdata;
    lastErr   = obsErr;
    $display("txn dut=%s %s addr=%h wdata=%h -> rdata=%h err=%b",
             sel ? "B" : "A", w ? "ST" : "LD", addr, d, lastRdata, lastErr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic randomTraffic(input int n);
    int          kind;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      addr = 32'hFFFF_0000 + 32'($urandom_range(0, 3) * 4);
      if (kind >= 9)      addr = $urandom;
      else if (kind >= 7) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) < 3) portIn = 8'($urandom);
      doReq(1'($urandom_range(0, 1)), addr, $urandom);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    sel = 1'b0; ws = 1; edgeNo = 0;
    reset = 1'b1; portIn = 8'd0;
    aValid = 0; aWrite = 0; aAddr = 0; aWdata = 0;
    bValid = 0; bWrite = 0; bAddr = 0; bWdata = 0;
    modelReset();
    idle(2);
    reset = 1'b0;
    check("reset_rdata", obsRdata, 32'd0);
    check("reset_error", {31'd0, obsErr}, 32'd0);

    // Store to PORT_OUT with one wait state
    doReq(1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF);
    check("st_portout_rdata", lastRdata, 32'd0);
    check("st_portout_err", {31'd0, lastErr}, 32'd0);
    check("st_portout_val", obsPortOut, 32'hDEAD_BEEF);

    // Synchronized input and sticky flag
    portIn = 8'hA5;
    idle(3);
    doReq(1'b0, 32'hFFFF_0004, 32'd0);
    check("ld_portin", lastRdata, 32'h0000_00A5);
    doReq(1'b0, 32'hFFFF_0008, 32'd0);
    check("ld_status", lastRdata, 32'd1);
    check("irq_set", {31'd0, obsIrq}, 32'd1);

    // W1C with a stable input, then W1C colliding with a new change
    doReq(1'b1, 32'hFFFF_0008, 32'd1);
    check("w1c_clear", {31'd0, obsIrq}, 32'd0);
    portIn = 8'h3C;
    cycle();
    doReq(1'b1, 32'hFFFF_0008, 32'd1);
    check("w1c_set_wins", {31'd0, obsIrq}, 32'd1);
    idle(2);
    doReq(1'b1, 32'hFFFF_0008, 32'd1);
    check("w1c_stable", {31'd0, obsIrq}, 32'd0);

    // Cycle counter wrap
    doReq(1'b1, 32'hFFFF_000C, 32'hFFFF_FFFE);
    idle(3);
    doReq(1'b0, 32'hFFFF_000C, 32'd0);
    check("cycles_wrapped", {31'd0, lastRdata < 32'd16}, 32'd1);

    // Misaligned and out-of-window accesses
    doReq(1'b0, 32'hFFFF_0002, 32'd0);
    check("misaligned_err", {31'd0, lastErr}, 32'd1);
    check("misaligned_rdata", lastRdata, 32'd0);
    doReq(1'b1, 32'h1001_0000, 32'h5555_AAAA);
    check("outwin_err", {31'd0, lastErr}, 32'd1);
    check("outwin_noside", obsPortOut, 32'hDEAD_BEEF);

    randomTraffic(40);

    // Reset while waiting after an accepted store
    for (int g = 0; g < 40 && !modelReady(); g++) cycle();
    drive(1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_1234);
    cycle();
    check("pre_reset_portout", obsPortOut, 32'h0000_1234);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_rsp_valid", {31'd0, obsRspValid}, 32'd0);
    check("abort_portout", obsPortOut, 32'd0);
    check("abort_ready", {31'd0, obsReady}, 32'd1);
    idle(3);

    // Zero-wait-state instance
    sel = 1'b1; ws = 0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    doReq(1'b0, 32'hFFFF_0002, 32'd0);
    check("b_misaligned_err", {31'd0, lastErr}, 32'd1);
    doReq(1'b0, 32'h1001_0000, 32'd0);
    check("b_outwin_rdata", lastRdata, 32'd0);
    doReq(1'b1, 32'hFFFF_0000, 32'hCAFE_F00D);
    doReq(1'b0, 32'hFFFF_0000, 32'd0);
    check("b_ld_portout", lastRdata, 32'hCAFE_F00D);
    randomTraffic(30);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
